geofence_sched: RTL and testbench

Round-robin scheduler that shares one `geofence` point-in-hexagon engine among up to `NREQ` requesters. A granted requester supplies seven points: the object point first, then six fence vertices. The block fetches them over a point-index bus and streams them into the engine on seven consecutive cycles. It then waits for the engine's `valid` and returns `is_inside` to the requester, with a timeout guard. It sits between the client ports and the engine, and owns the engine's reset.

---
 rtl/geofence_sched.sv | 169 ++++++++++++++++
 tb/tb_geofence_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/geofence_sched.sv
// geofence_sched: round-robin share of one geofence engine among NREQ clients.
// Fetches 7 points per job, streams them to the engine, returns is_inside.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req, gnt              per-client level request / one-hot job grant
//   req_x, req_y          client point bus, slice i = client i, indexed by pt_idx
//   pt_req, pt_idx        point fetch strobe and point index 0..6
//   eng_reset             engine reset, high whenever no job is running
//   eng_x, eng_y          registered point to the engine
//   eng_valid             engine result strobe
//   eng_is_inside         engine result
//   resp_valid            one-cycle response pulse
//   resp_id               client the response belongs to
//   resp_inside           object point is inside the fence
//   resp_err              job timed out
//   busy                  any state but IDLE
module geofence_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 63,
  localparam int IDW    = (NREQ <= 2) ? 1 : $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*10-1:0] req_x,
  input  logic [NREQ*10-1:0] req_y,
  output logic [NREQ-1:0]  gnt,
  output logic             pt_req,
  output logic [2:0]       pt_idx,
  output logic             eng_reset,
  output logic [9:0]       eng_x,
  output logic [9:0]       eng_y,
  input  logic             eng_valid,
  input  logic             eng_is_inside,
  output logic             resp_valid,
  output logic [IDW-1:0]   resp_id,
  output logic             resp_inside,
  output logic             resp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_FEED,
    S_WAIT
  } state_t;

  state_t state, state_nx;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic [2:0]     jcnt;
  logic [7:0]     wcnt;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW:0]   cand;

  logic load_gnt;
  logic done_ok;
  logic done_to;

  // first requester at or after rr_ptr+1, wrapping mod NREQ
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ))
        cand = cand - (IDW+1)'(NREQ);
      if (!win_found && req[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    pt_req    = 1'b0;
    pt_idx    = 3'd0;
    eng_reset = 1'b0;
    busy      = 1'b1;
    load_gnt  = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    unique case (state)
      S_IDLE: begin
        eng_reset = 1'b1;
        busy      = 1'b0;
        if (win_found) begin
          load_gnt = 1'b1;
          state_nx = S_PRIME;
        end
      end
      S_PRIME: begin
        pt_req   = 1'b1;
        state_nx = S_FEED;
      end
      S_FEED: begin
        if (jcnt != 3'd6) begin
          pt_req = 1'b1;
          pt_idx = jcnt + 3'd1;
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        // a result in the timeout cycle still counts as a result
        if (eng_valid) begin
          done_ok  = 1'b1;
          state_nx = S_IDLE;
        end else if (wcnt == 8'(TIMEOUT)) begin
          done_to  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt         <= '0;
      gnt_id      <= '0;
      rr_ptr      <= IDW'(NREQ-1);
      jcnt        <= '0;
      wcnt        <= '0;
      eng_x       <= '0;
      eng_y       <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_inside <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (load_gnt) begin
        gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << win_id;
        gnt_id <= win_id;
        rr_ptr <= win_id;
      end
      if (pt_req) begin
        eng_x <= req_x[gnt_id*10 +: 10];
        eng_y <= req_y[gnt_id*10 +: 10];
      end
      if (state == S_FEED) jcnt <= jcnt + 3'd1;
      else                 jcnt <= '0;
      // WAIT cycle count starts at 1
      if (state == S_WAIT) wcnt <= wcnt + 8'd1;
      else                 wcnt <= 8'd1;
      if (done_ok || done_to) begin
        gnt         <= '0;
        resp_valid  <= 1'b1;
        resp_id     <= gnt_id;
        resp_inside <= done_ok & eng_is_inside;
        resp_err    <= done_to;
      end
    end
  end

endmodule

// File: tb/tb_geofence_sched.sv
// tb_geofence_sched: directed scoreboard bench for geofence_sched.
// Includes a behavioural hexagon engine that answers at WAIT cycle 23.
module tb_geofence_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ*10-1:0] req_x, req_y;
  logic [NREQ-1:0] gnt;
  logic            pt_req;
  logic [2:0]      pt_idx;
  logic            eng_reset;
  logic [9:0]      eng_x, eng_y;
  logic            eng_valid;
  logic            eng_is_inside;
  logic            resp_valid;
  logic [IDW-1:0]  resp_id;
  logic            resp_inside;
  logic            resp_err;
  logic            busy;

  geofence_sched #(.NREQ(NREQ), .TIMEOUT(63)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_x(req_x), .req_y(req_y), .gnt(gnt),
    .pt_req(pt_req), .pt_idx(pt_idx),
    .eng_reset(eng_reset), .eng_x(eng_x), .eng_y(eng_y),
    .eng_valid(eng_valid), .eng_is_inside(eng_is_inside),
    .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_inside(resp_inside), .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // client point tables
  int tx[NREQ][7];
  int ty[NREQ][7];

  always_comb begin
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*10 +: 10] = 10'(tx[i][pt_idx]);
      req_y[i*10 +: 10] = 10'(ty[i][pt_idx]);
    end
  end

  // behavioural engine: idle one cycle, takes 7 points,
  // answers so that the result lands in WAIT cycle 23
  int  px[7], py[7];
  int  ek;
  logic eng_mute = 1'b0;
  logic spur = 1'b0;
  logic ev_m, ein_m;

  function automatic logic hex_in();
    int pos, neg, j;
    longint cr;
    pos = 0;
    neg = 0;
    for (int i = 0; i < 6; i++) begin
      j  = (i == 5) ? 0 : i + 1;
      cr = longint'(px[j+1] - px[i+1]) * (py[0] - py[i+1])
         - longint'(py[j+1] - py[i+1]) * (px[0] - px[i+1]);
      if (cr > 0) pos++;
      if (cr < 0) neg++;
    end
    return (pos == 6) || (neg == 6);
  endfunction

  always @(posedge clk) begin
    if (eng_reset) begin
      ek   <= 0;
      ev_m <= 1'b0;
      ein_m <= 1'b0;
    end else begin
      ek <= ek + 1;
      if (ek >= 1 && ek <= 7) begin
        px[ek-1] <= int'(eng_x);
        py[ek-1] <= int'(eng_y);
      end
      ev_m  <= (ek == 29) && !eng_mute;
      ein_m <= hex_in();
    end
  end

  assign eng_valid     = ev_m | spur;
  assign eng_is_inside = ein_m;

  // scoreboard
  typedef struct {
    int cy;
    int id;
    bit ins;
    bit err;
  } exp_t;

  exp_t sbq[$];

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 required 0 (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("resp_cycle", cyc, e.cy);
        chk("resp_id", 32'(resp_id), e.id);
        chk("resp_inside", 32'(resp_inside), 32'(e.ins));
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input int cy, input int id,
                      input bit ins, input bit err);
    exp_t e;
    e.cy  = cy;
    e.id  = id;
    e.ins = ins;
    e.err = err;
    sbq.push_back(e);
  endtask

  int c, c2;
  int vx[6] = '{400, 450, 550, 600, 550, 450};
  int vy[6] = '{500, 413, 413, 500, 587, 587};
  int p0x[NREQ] = '{500, 480, 900, 500};
  int p0y[NREQ] = '{500, 520, 900, 450};
  int ex_seq[7] = '{500, 400, 450, 550, 600, 550, 450};

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      tx[i][0] = p0x[i];
      ty[i][0] = p0y[i];
      for (int k = 0; k < 6; k++) begin
        tx[i][k+1] = vx[k];
        ty[i][k+1] = vy[k];
      end
    end
    req   = '0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_eng_reset", 32'(eng_reset), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pt_req", 32'(pt_req), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_eng_x", 32'(eng_x), 0);
    reset = 1'b0;

    // inside, client 0
    tick();
    c = cyc;
    req = 4'b0001;
    push(c + 32, 0, 1'b1, 1'b0);
    go_until(c + 1);
    chk("t1_gnt", 32'(gnt), 1);
    chk("t1_pt_idx_prime", 32'(pt_idx), 0);
    for (int j = 0; j < 7; j++) begin
      go_until(c + 2 + j);
      chk("t1_eng_x", 32'(eng_x), ex_seq[j]);
    end
    go_until(c + 9);
    chk("t1_pt_req_wait", 32'(pt_req), 0);
    go_until(c + 20);
    req = '0;
    go_until(c + 33);

    // outside, client 2
    do_reset();
    tick();
    c = cyc;
    req = 4'b0100;
    push(c + 32, 2, 1'b0, 1'b0);
    go_until(c + 1);
    chk("t2_gnt", 32'(gnt), 4);
    go_until(c + 20);
    req = '0;
    go_until(c + 33);

    // round-robin fairness
    do_reset();
    tick();
    c = cyc;
    req = 4'b1111;
    for (int k = 0; k < 5; k++)
      push(c + 32 * (k + 1), k % 4, (k % 4) != 2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      go_until(c + 1 + 32 * k);
      chk("t3_gnt", 32'(gnt), 32'(1 << (k % 4)));
    end
    req = '0;
    go_until(c + 162);
    chk("t3_idle", 32'(busy), 0);

    // timeout
    do_reset();
    eng_mute = 1'b1;
    tick();
    c = cyc;
    req = 4'b0001;
    push(c + 72, 0, 1'b0, 1'b1);
    go_until(c + 20);
    req = '0;
    go_until(c + 71);
    chk("t4_busy_wait", 32'(busy), 1);
    go_until(c + 72);
    chk("t4_eng_reset", 32'(eng_reset), 1);
    go_until(c + 74);
    eng_mute = 1'b0;

    // reset during FEED j=3
    do_reset();
    tick();
    c = cyc;
    req = 4'b0010;
    go_until(c + 5);
    chk("t5_eng_x_j3", 32'(eng_x), 550);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_gnt", 32'(gnt), 0);
    chk("t5_eng_reset", 32'(eng_reset), 1);
    chk("t5_resp_valid", 32'(resp_valid), 0);
    c2 = cyc;
    push(c2 + 32, 1, 1'b1, 1'b0);
    go_until(c2 + 1);
    chk("t5_regrant", 32'(gnt), 2);
    go_until(c2 + 20);
    req = '0;
    go_until(c2 + 33);

    // spurious strobes in IDLE and FEED
    do_reset();
    tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("t6_idle_spur", 32'(resp_valid), 0);
    tick();
    c = cyc;
    req = 4'b0001;
    push(c + 32, 0, 1'b1, 1'b0);
    go_until(c + 4);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    go_until(c + 7);
    chk("t6_busy_feed", 32'(busy), 1);
    go_until(c + 20);
    req = '0;
    go_until(c + 33);

    for (int k = 0; k < 100 && sbq.size() != 0; k++) tick();
    chk("sb_drained", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
